fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Program-counter and fetch-control stage directly upstream of the instruction memory.
// - Drives the word address into the synchronous-read (1-cycle) instruction memory.
// - Tracks which PC each returned word belongs to.
// - Holds the delivered instruction across decode stalls.
// - Flushes wrong-path words on a control-flow redirect.
// PARAMETERS
// RESET_PC  32'h0000_0000  byte PC fetched first after reset (bits [1:0] must be 0)
// ADDR_W    9              memory word-address width (512 words = MEM_SIZE)
// PORTS
// clk          in   1       clock, all state updates on posedge
// rst          in   1       synchronous, active-high reset
// stall        in   1       downstream not ready; hold current output
// redirect     in   1       branch/jump taken; restart fetch at redirect_pc
// redirect_pc  in   32      byte target PC; bits [1:0] ignored (treated as 0)
// address      out  ADDR_W  word address to instruction memory = pc_q[ADDR_W+1:2]
// instruction  in   32      registered memory output (word at address of previous edge)
// fetch_instr  out  32      instruction to decode
// fetch_pc     out  32      byte PC of fetch_instr
// fetch_valid  out  1       fetch_instr/fetch_pc are a real in-order instruction
// BEHAVIOUR
// State
// - pc_q: next PC presented to memory.
// - rsp_pc_q, rsp_valid_q: PC and validity of the word now on `instruction`.
// - held_q, hold_instr_q: stall skid register.
// Reset (rst=1 at edge)
// - Sets pc_q=RESET_PC, rsp_pc_q=RESET_PC, rsp_valid_q=0, held_q=0, hold_instr_q=0.
// - Outputs after reset: fetch_valid=0, fetch_pc=RESET_PC, fetch_instr=32'h0000_0013,
//   address=RESET_PC[ADDR_W+1:2].
// Outputs
// - fetch_valid = rsp_valid_q; fetch_pc = rsp_pc_q.
// - fetch_instr = !rsp_valid_q ? 32'h0000_0013 (NOP) : held_q ? hold_instr_q : instruction.
// Priority per edge: rst > redirect > stall > advance.
// - Advance: rsp_pc_q<=pc_q; rsp_valid_q<=1; pc_q<=pc_q+4; held_q<=0.
// - Stall: pc_q, rsp_pc_q and rsp_valid_q hold.
//   - If rsp_valid_q && !held_q: hold_instr_q<=instruction; held_q<=1.
//   - address stays pc_q, so on release the memory output matches rsp_pc_q<=pc_q:
//     no skip, no duplicate.
// - Redirect (default):
//   - pc_q<={redirect_pc[31:2],2'b00}; rsp_valid_q<=0; held_q<=0.
//   - Target delivered valid 2 cycles after redirect is sampled (1 bubble).
// - Redirect overrides stall; any held instruction is discarded.
// Arithmetic
// - pc_q+4 wraps mod 2^32.
// - address is a bit-slice, so it wraps mod 2^ADDR_W (PC 0x7FC -> 0x800 gives address 511 -> 0).
// Other boundaries
// - Stall while rsp_valid_q=0: everything holds, no capture, fetch_valid stays 0.
// - rst asserted mid-stall or mid-redirect: reset values apply next cycle; held data is lost.
// - fetch_valid is never 1 for a word fetched before the most recent redirect or reset.
// CONFIGURATION
// FETCH_REDIRECT_BYPASS_EN
// - Defined:
//   - address = redirect ? redirect_pc[ADDR_W+1:2] : pc_q[ADDR_W+1:2] (combinational).
//   - On redirect: rsp_pc_q<=target; rsp_valid_q<=1; pc_q<=target+4; held_q<=0.
//   - Target is valid 1 cycle after redirect, with no bubble.
//   - Redirect still overrides stall.
// - Undefined: address = pc_q slice only (fully registered); 1-cycle redirect bubble as above.
// TESTING
// T1 reset/stream: RESET_PC=0, rst high 2 cycles, mem[i]=i+0x100
//    -> fetch_valid=0, fetch_instr=0x13 during reset;
//    -> first edge after release: valid=1, pc=0, instr=0x100; then pc 4,8,... instr 0x101,0x102,...
// T2 stall: stall=1 for 3 cycles while pc=4 shown
//    -> instr stays 0x101, pc stays 4;
//    -> after release next valid is pc=8 instr=0x102 (no skip/dup).
// T3 redirect: redirect=1, redirect_pc=0x100 at cycle n
//    -> n+1: valid=0; n+2: valid=1, pc=0x100, instr=mem[64].
//    -> With FETCH_REDIRECT_BYPASS_EN: valid at n+1.
// T4 redirect during stall: stall=1, redirect=1, redirect_pc=0x23
//    -> held word dropped; target pc=0x20, instr=mem[8] delivered at default latency.
// T5 wrap: redirect_pc=0x7FC -> pc 0x7FC instr mem[511], then pc 0x800 with address=0, instr mem[0].
// T6 reset mid-stall: stall=1, rst=1 for 1 cycle
//    -> next cycle valid=0, pc=RESET_PC; stream restarts at mem[0].

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: drives the PC into a 1-cycle instruction memory, tags returned words, skids across stalls.
// Optional FETCH_REDIRECT_BYPASS_EN sends the redirect target straight to memory, so redirects cost no bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] address,
  input  logic [31:0]       instruction,
  output logic [31:0]       fetch_instr,
  output logic [31:0]       fetch_pc,
  output logic              fetch_valid
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        held_q, held_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] target_s;

  assign target_s = redirect_pc & 32'hFFFF_FFFC;

  // Next-state selection: redirect beats stall, stall beats advance.
  always_comb begin
    pc_d         = pc_q;
    rsp_pc_d     = rsp_pc_q;
    rsp_valid_d  = rsp_valid_q;
    held_d       = held_q;
    hold_instr_d = hold_instr_q;
    if (redirect) begin
`ifdef FETCH_REDIRECT_BYPASS_EN
      rsp_pc_d    = target_s;
      rsp_valid_d = 1'b1;
      pc_d        = target_s + 32'd4;
`else
      pc_d        = target_s;
      rsp_valid_d = 1'b0;
`endif
      held_d      = 1'b0;
    end else if (stall) begin
      // The address keeps presenting pc_q, so only the first stalled word needs capturing.
      if (rsp_valid_q && !held_q) begin
        hold_instr_d = instruction;
        held_d       = 1'b1;
      end else begin
        held_d       = held_q;
      end
    end else begin
      rsp_pc_d    = pc_q;
      rsp_valid_d = 1'b1;
      pc_d        = pc_q + 32'd4;
      held_d      = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      held_q       <= 1'b0;
      hold_instr_q <= 32'h0000_0000;
    end else begin
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      rsp_valid_q  <= rsp_valid_d;
      held_q       <= held_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Memory word address; the slice makes it wrap modulo the memory size.
  always_comb begin
`ifdef FETCH_REDIRECT_BYPASS_EN
    if (redirect) begin
      address = target_s[ADDR_W+1:2];
    end else begin
      address = pc_q[ADDR_W+1:2];
    end
`else
    address = pc_q[ADDR_W+1:2];
`endif
  end

  // Delivered instruction: NOP when invalid, skid copy while a stall is held.
  always_comb begin
    if (!rsp_valid_q) begin
      fetch_instr = NOP_INSTR;
    end else if (held_q) begin
      fetch_instr = hold_instr_q;
    end else begin
      fetch_instr = instruction;
    end
  end

  assign fetch_pc    = rsp_pc_q;
  assign fetch_valid = rsp_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: architectural PC/validity model checked every cycle, plus literal spot checks.
module tb_fetch_unit;

`ifdef FETCH_REDIRECT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [8:0]  address;
  logic [31:0] instruction, fetch_instr, fetch_pc;
  logic        fetch_valid;

  logic [31:0] mem [512];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(RST_PC), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .address(address), .instruction(instruction),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) instruction <= mem[address];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Architectural model: which PC is being shown and which PC comes next.
  bit          m_live = 1'b0;
  bit          m_valid;
  logic [31:0] m_pc, m_next;

  always @(posedge clk) begin
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      m_live = 1'b1; m_valid = 1'b0; m_pc = RST_PC; m_next = RST_PC;
    end else if (redirect) begin
      if (BYP) begin
        m_valid = 1'b1; m_pc = tgt; m_next = tgt + 32'd4;
      end else begin
        m_valid = 1'b0; m_next = tgt;
      end
    end else if (!stall) begin
      m_valid = 1'b1; m_pc = m_next; m_next = m_next + 32'd4;
    end
  end

  // Every-cycle comparison: a valid word must be exactly the memory word at its PC.
  always @(negedge clk) begin
    logic [31:0] e_instr;
    logic [8:0]  e_addr;
    if (m_live) begin
      e_instr = m_valid ? mem[m_pc[10:2]] : 32'h0000_0013;
      e_addr  = (BYP && redirect) ? redirect_pc[10:2] : m_next[10:2];
      chk("model_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
      chk("model_instr", fetch_instr, e_instr);
      chk("model_pc", fetch_pc, m_pc);
      chk("model_addr", {23'd0, address}, {23'd0, e_addr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({name, "_valid"}, {31'd0, fetch_valid}, {31'd0, v});
    chk({name, "_pc"}, fetch_pc, pc);
    chk({name, "_instr"}, fetch_instr, ins);
  endtask

  typedef struct { bit s; bit r; logic [31:0] pc; } vec_t;
  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = i + 32'h100;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // T1 reset and streaming
    tick();
    expect_out("t1_rst", 1'b0, 32'h0, 32'h0000_0013);
    chk("t1_rst_addr", {23'd0, address}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); expect_out("t1_s0", 1'b1, 32'h0, 32'h100);
    tick(); expect_out("t1_s1", 1'b1, 32'h4, 32'h101);

    // T2 stall for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("t2_hold", 1'b1, 32'h4, 32'h101);
    end
    stall = 1'b0;
    tick(); expect_out("t2_rel", 1'b1, 32'h8, 32'h102);

    // T3 redirect
    redirect = 1'b1; redirect_pc = 32'h100;
    tick(); chk("t3_n1_valid", {31'd0, fetch_valid}, {31'd0, BYP});
    redirect = 1'b0;
    tick(); expect_out("t3_n2", 1'b1, BYP ? 32'h104 : 32'h100, BYP ? 32'h141 : 32'h140);

    // T4 redirect during stall drops the held word
    stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h23;
    tick(); chk("t4_n1_valid", {31'd0, fetch_valid}, {31'd0, BYP});
    redirect = 1'b0; stall = 1'b0;
    tick(); expect_out("t4_n2", 1'b1, BYP ? 32'h24 : 32'h20, BYP ? 32'h109 : 32'h108);

    // T5 address wrap
    redirect = 1'b1; redirect_pc = 32'h7FC;
    tick();
    redirect = 1'b0;
    tick();
    expect_out("t5_a", 1'b1, BYP ? 32'h800 : 32'h7FC, BYP ? 32'h100 : 32'h2FF);
    chk("t5_addr", {23'd0, address}, BYP ? 32'd1 : 32'd0);
    tick(); expect_out("t5_b", 1'b1, BYP ? 32'h804 : 32'h800, BYP ? 32'h101 : 32'h100);

    // Stall during the redirect bubble
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    tick();
    redirect = 1'b0;
    tick(); chk("bub_valid", {31'd0, fetch_valid}, {31'd0, BYP});
    stall = 1'b0;
    tick(); expect_out("bub_rel", 1'b1, BYP ? 32'h44 : 32'h40, BYP ? 32'h111 : 32'h110);

    // T6 reset mid-stall
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick(); expect_out("t6_rst", 1'b0, RST_PC, 32'h0000_0013);
    rst = 1'b0; stall = 1'b0;
    tick(); expect_out("t6_s0", 1'b1, 32'h0, 32'h100);
    tick(); expect_out("t6_s1", 1'b1, 32'h4, 32'h101);

    // Mixed directed vectors, checked by the model
    vecs[0] = '{1'b1, 1'b0, 32'h0};   vecs[1] = '{1'b1, 1'b1, 32'h3F2};
    vecs[2] = '{1'b0, 1'b0, 32'h0};   vecs[3] = '{1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h7F8}; vecs[5] = '{1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h0};   vecs[7] = '{1'b0, 1'b0, 32'h0};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        stall = vecs[i].s; redirect = vecs[i].r; redirect_pc = vecs[i].pc;
        tick();
      end
    end
    stall = 1'b0; redirect = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
